// File: rtl/lp_ecc_collect_pkg.sv
// rtl/lp_ecc_collect_pkg.sv - error class encodings and beat classifier for the arrive collector
package lp_ecc_collect_pkg;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_CORR   = 2'b01;
  localparam logic [1:0] ERR_UNCORR = 2'b11;

  // An uncorrectable flag dominates; err_detect alone means the decoder fixed the word.
  function automatic logic [1:0] classify(input logic err_detect, input logic err_multiple);
    if (err_multiple) begin
      return ERR_UNCORR;
    end
    if (err_detect) begin
      return ERR_CORR;
    end
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/lp_ecc_collect_fifo.sv
// rtl/lp_ecc_collect_fifo.sv - register FIFO holding captured arrive beats
module lp_ecc_collect_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage is cleared on reset so the head outputs read zero until the first capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lp_ecc_arrive_collector.sv
// rtl/lp_ecc_arrive_collector.sv - captures ECC arrive beats, classifies them, keeps error stats
module lp_ecc_arrive_collector
  import lp_ecc_collect_pkg::*;
#(
  parameter int DATA_WIDTH = 27,
  parameter int CHK_WIDTH  = 7,
  parameter int ID_WIDTH   = 1,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arrive,
  input  logic [ID_WIDTH-1:0]   arrive_id,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic                  err_detect,
  input  logic                  err_multiple,
  input  logic [CHK_WIDTH-1:0]  syndin,
  output logic                  accept_n,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [1:0]            out_err,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt,
  output logic [CHK_WIDTH-1:0]  last_bad_synd,
  output logic [ID_WIDTH-1:0]   last_bad_id,
  output logic                  id_err,
  output logic                  err_irq
);

  localparam int EW = DATA_WIDTH + ID_WIDTH + 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]           w_class;
  logic                 w_push;
  logic                 w_pop;
  logic [EW-1:0]        w_rd_entry;
  logic [CW-1:0]        w_count;
  logic                 w_full;
  logic                 w_empty;

  logic [CNT_WIDTH-1:0] r_corr_cnt;
  logic [CNT_WIDTH-1:0] r_uncorr_cnt;
  logic [CHK_WIDTH-1:0] r_last_bad_synd;
  logic [ID_WIDTH-1:0]  r_last_bad_id;
  logic                 r_id_err;
  logic                 r_err_irq;
  logic [ID_WIDTH-1:0]  r_exp_id;

  logic [CNT_WIDTH-1:0] w_corr_base;
  logic [CNT_WIDTH-1:0] w_uncorr_base;
  logic [CNT_WIDTH-1:0] w_corr_nxt;
  logic [CNT_WIDTH-1:0] w_uncorr_nxt;
  logic                 w_id_err_nxt;
  logic                 w_err_irq_nxt;

  assign w_class = classify(err_detect, err_multiple);

  // accept_n comes only from the registered occupancy so the pipe never sees out_ready.
  assign accept_n  = (w_count == CW'(DEPTH));
  assign w_push    = arrive & ~w_full;
  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;

  lp_ecc_collect_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({arrive_id, w_class, datain}),
    .i_pop   (w_pop),
    .o_data  (w_rd_entry),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {out_id, out_err, out_data} = w_rd_entry;

  // A clear in the same cycle as a capture is applied first, then the captured beat counts.
  always_comb begin
    w_corr_base   = clr_stats ? '0 : r_corr_cnt;
    w_uncorr_base = clr_stats ? '0 : r_uncorr_cnt;
    w_corr_nxt    = w_corr_base;
    w_uncorr_nxt  = w_uncorr_base;
    w_id_err_nxt  = clr_stats ? 1'b0 : r_id_err;
    w_err_irq_nxt = clr_stats ? 1'b0 : r_err_irq;
    if (w_push) begin
      if (w_class == ERR_CORR && w_corr_base != '1) begin
        w_corr_nxt = w_corr_base + CNT_WIDTH'(1);
      end
      if (w_class == ERR_UNCORR) begin
        w_err_irq_nxt = 1'b1;
        if (w_uncorr_base != '1) begin
          w_uncorr_nxt = w_uncorr_base + CNT_WIDTH'(1);
        end
      end
      if (arrive_id != r_exp_id) begin
        w_id_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_cnt      <= '0;
      r_uncorr_cnt    <= '0;
      r_last_bad_synd <= '0;
      r_last_bad_id   <= '0;
      r_id_err        <= 1'b0;
      r_err_irq       <= 1'b0;
      r_exp_id        <= '0;
    end else begin
      r_corr_cnt   <= w_corr_nxt;
      r_uncorr_cnt <= w_uncorr_nxt;
      r_id_err     <= w_id_err_nxt;
      r_err_irq    <= w_err_irq_nxt;
      if (w_push) begin
        r_exp_id <= arrive_id + ID_WIDTH'(1);
        if (w_class == ERR_UNCORR) begin
          r_last_bad_synd <= syndin;
          r_last_bad_id   <= arrive_id;
        end
      end
    end
  end

  assign corr_cnt      = r_corr_cnt;
  assign uncorr_cnt    = r_uncorr_cnt;
  assign last_bad_synd = r_last_bad_synd;
  assign last_bad_id   = r_last_bad_id;
  assign id_err        = r_id_err;
  assign err_irq       = r_err_irq;

endmodule
